// File: rtl/sa_pkg.sv
// Shared types and default widths for the systolic-array partial-sum accumulator.
package sa_pkg;

  typedef enum logic {IDLE, ACC} acc_state_t;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 24;
  localparam int LEN_W  = 16;

endpackage

// File: rtl/sa_psum_accumulator_sat_adder.sv
// Unsigned ACC_W + PROD_W adder with carry-out overflow and optional clamp to all-ones.
module sat_adder #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic [ACC_W:0] w_full;

  always_comb begin
    w_full = {1'b0, i_a} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_b};
    o_ovf  = w_full[ACC_W];
    if (SAT_EN && w_full[ACC_W]) o_sum = '1;
    else                         o_sum = w_full[ACC_W-1:0];
  end

endmodule

// File: rtl/sa_psum_accumulator.sv
// Per-PE product accumulator: sums a programmable number of products per context
// and hands each result to the drain path through a one-entry output register.
module sa_psum_accumulator
  import sa_pkg::*;
#(
  parameter int PROD_W = sa_pkg::PROD_W,
  parameter int ACC_W  = sa_pkg::ACC_W,
  parameter int LEN_W  = sa_pkg::LEN_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf,
  output logic              o_acc_valid,
  input  logic              i_acc_ready,
  output logic              o_busy
);

  acc_state_t        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_ovf;
  logic [ACC_W-1:0]  r_out_acc;
  logic              r_out_ovf;
  logic              r_out_full;

  logic [LEN_W-1:0]  w_len_eff;
  logic              w_final_pending;
  logic              w_beat;
  logic              w_drain;
  logic [ACC_W-1:0]  w_add_a;
  logic [ACC_W-1:0]  w_sum;
  logic              w_carry;
  logic              w_ovf_prev;

  always_comb begin
    w_len_eff       = (i_len == '0) ? LEN_W'(1) : i_len;
    w_final_pending = (r_state == ACC) ? (r_cnt == r_len - LEN_W'(1))
                                       : (w_len_eff == LEN_W'(1));
    // The first beat of a context adds to zero, so the open accumulator is never read in IDLE.
    w_add_a         = (r_state == ACC) ? r_acc : '0;
    w_ovf_prev      = (r_state == ACC) && r_ovf;
  end

  assign o_prod_ready = !(w_final_pending && r_out_full && !i_acc_ready);
  assign w_beat       = i_prod_valid && o_prod_ready;
  assign w_drain      = r_out_full && i_acc_ready;

  sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_sat_adder (
    .i_a   (w_add_a),
    .i_b   (i_prod),
    .o_sum (w_sum),
    .o_ovf (w_carry)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_out_acc  <= '0;
      r_out_ovf  <= 1'b0;
      r_out_full <= 1'b0;
    end else begin
      // A final beat coinciding with a drain overwrites the register and keeps it full.
      if (w_beat && w_final_pending) begin
        r_out_acc  <= w_sum;
        r_out_ovf  <= w_ovf_prev || w_carry;
        r_out_full <= 1'b1;
      end else if (w_drain) begin
        r_out_full <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_beat && !w_final_pending) begin
            r_acc   <= w_sum;
            r_cnt   <= LEN_W'(1);
            r_len   <= w_len_eff;
            r_ovf   <= 1'b0;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (w_beat) begin
            if (w_final_pending) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + LEN_W'(1);
              r_ovf <= r_ovf || w_carry;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_acc       = r_out_acc;
  assign o_ovf       = r_out_ovf;
  assign o_acc_valid = r_out_full;
  assign o_busy      = (r_state == ACC);

endmodule

// File: tb/tb_sa_psum_accumulator.sv
// Scoreboard bench: default 24-bit instance plus 9-bit saturating and wrapping instances
// all driven by the same product stream.
module tb_sa_psum_accumulator;

  logic        clk;
  logic        rstn;
  logic [7:0]  r_prod;
  logic        r_valid;
  logic [15:0] r_len;
  logic        r_acc_ready;

  logic        rdy0, rdy_s, rdy_w;
  logic [23:0] acc0;
  logic [8:0]  acc_s, acc_w;
  logic        ovf0, ovf_s, ovf_w;
  logic        val0, val_s, val_w;
  logic        busy0, busy_s, busy_w;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [23:0] a0;
    logic        o0;
    logic [8:0]  as;
    logic        os;
    logic [8:0]  aw;
    logic        ow;
  } exp_t;

  exp_t sb[$];

  sa_psum_accumulator u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_prod(r_prod), .i_prod_valid(r_valid),
    .o_prod_ready(rdy0), .i_len(r_len), .o_acc(acc0), .o_ovf(ovf0),
    .o_acc_valid(val0), .i_acc_ready(r_acc_ready), .o_busy(busy0));

  sa_psum_accumulator #(.ACC_W(9), .SAT_EN(1'b1)) u_dut_sat (
    .i_clk(clk), .i_rstn(rstn), .i_prod(r_prod), .i_prod_valid(r_valid),
    .o_prod_ready(rdy_s), .i_len(r_len), .o_acc(acc_s), .o_ovf(ovf_s),
    .o_acc_valid(val_s), .i_acc_ready(r_acc_ready), .o_busy(busy_s));

  sa_psum_accumulator #(.ACC_W(9), .SAT_EN(1'b0)) u_dut_wrap (
    .i_clk(clk), .i_rstn(rstn), .i_prod(r_prod), .i_prod_valid(r_valid),
    .o_prod_ready(rdy_w), .i_len(r_len), .o_acc(acc_w), .o_ovf(ovf_w),
    .o_acc_valid(val_w), .i_acc_ready(r_acc_ready), .o_busy(busy_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int unsigned total);
    exp_t e;
    e.a0 = 24'(total);
    e.o0 = (total > 32'hFF_FFFF);
    e.as = (total > 511) ? 9'd511 : 9'(total);
    e.os = (total > 511);
    e.aw = 9'(total % 512);
    e.ow = (total > 511);
    return e;
  endfunction

  task automatic push_exp(input int unsigned total);
    sb.push_back(mk(total));
  endtask

  // Present one product and hold it until accepted; returns #1 after the accepting edge.
  task automatic beat(input logic [7:0] p, input logic [15:0] l);
    int unsigned n;
    n = 0;
    r_valid = 1'b1;
    r_prod  = p;
    r_len   = l;
    @(negedge clk);
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("beat_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    r_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"},   32'(acc0),  32'd0);
    check({tag, "_ovf"},   32'(ovf0),  32'd0);
    check({tag, "_valid"}, 32'(val0),  32'd0);
    check({tag, "_busy"},  32'(busy0), 32'd0);
    check({tag, "_ready"}, 32'(rdy0),  32'd1);
    check({tag, "_sat_acc"}, 32'(acc_s), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rstn && val0 && r_acc_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'(acc0), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc24",   32'(acc0),  32'(e.a0));
        check("ovf24",   32'(ovf0),  32'(e.o0));
        check("valid_sat",  32'(val_s), 32'd1);
        check("acc_sat",    32'(acc_s), 32'(e.as));
        check("ovf_sat",    32'(ovf_s), 32'(e.os));
        check("valid_wrap", 32'(val_w), 32'd1);
        check("acc_wrap",   32'(acc_w), 32'(e.aw));
        check("ovf_wrap",   32'(ovf_w), 32'(e.ow));
      end
    end
  end

  initial begin
    rstn = 1'b0; r_prod = '0; r_valid = 1'b0; r_len = '0; r_acc_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic context: 4 x 225
    push_exp(900);
    beat(8'd225, 16'd4);
    check("busy_open", 32'(busy0), 32'd1);
    beat(8'd225, 16'd4);
    beat(8'd225, 16'd4);
    check("valid_before_final", 32'(val0), 32'd0);
    beat(8'd225, 16'd4);
    check("valid_latency", 32'(val0), 32'd1);
    check("busy_closed", 32'(busy0), 32'd0);
    @(posedge clk); #1;
    check("valid_pulse", 32'(val0), 32'd0);

    // i_len = 0 acts as length 1
    push_exp(49);
    beat(8'd49, 16'd0);
    check("len0_valid", 32'(val0), 32'd1);
    check("len0_busy", 32'(busy0), 32'd0);

    // Three single-product contexts back to back
    push_exp(1); push_exp(2); push_exp(3);
    beat(8'd1, 16'd1);
    beat(8'd2, 16'd1);
    beat(8'd3, 16'd1);
    @(posedge clk); #1;

    // Backpressure
    r_acc_ready = 1'b0;
    push_exp(30);
    beat(8'd10, 16'd2);
    beat(8'd20, 16'd2);
    push_exp(70);
    beat(8'd30, 16'd2);
    r_valid = 1'b1; r_prod = 8'd40; r_len = 16'd2;
    repeat (2) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(rdy0), 32'd0);
      check("bp_hold_acc", 32'(acc0), 32'd30);
      check("bp_hold_valid", 32'(val0), 32'd1);
    end
    @(posedge clk); #1;
    r_acc_ready = 1'b1;
    beat(8'd40, 16'd2);
    check("bp_new_valid", 32'(val0), 32'd1);
    @(posedge clk); #1;

    // Overflow: 3 x 255 (saturates / wraps on the 9-bit instances)
    push_exp(765);
    beat(8'd255, 16'd3);
    beat(8'd255, 16'd3);
    beat(8'd255, 16'd3);
    push_exp(5);
    beat(8'd5, 16'd1);
    @(posedge clk); #1;

    // Reset in the middle of an 8-product context
    beat(8'd11, 16'd8);
    beat(8'd12, 16'd8);
    beat(8'd13, 16'd8);
    check("mid_busy", 32'(busy0), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rstn = 1'b1;
    push_exp(15);
    beat(8'd7, 16'd2);
    beat(8'd8, 16'd2);

    // A few random contexts
    for (int k = 0; k < 6; k++) begin
      int unsigned len, n, total;
      logic [7:0] p [4];
      len = $urandom_range(0, 4);
      n = (len == 0) ? 1 : len;
      total = 0;
      for (int unsigned j = 0; j < n; j++) begin
        p[j] = 8'($urandom_range(0, 255));
        total += p[j];
      end
      push_exp(total);
      for (int unsigned j = 0; j < n; j++) beat(p[j], 16'(len));
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
